// File: rtl/seg_scan_if.sv
// Bus bundle for the multiplexed seven-segment driver: control and value
// inputs from the host side, busy flag and digit/segment drive back.
interface seg_scan_if #(
  parameter int DIGITS = 8,
  parameter int NUM_W  = 32
);
  logic              enable;
  logic              load;
  logic [NUM_W-1:0]  num;
  logic              dec_mode;
  logic              blank_lz;
  logic [DIGITS-1:0] dp;
  logic [DIGITS-1:0] blink_mask;
  logic              busy;
  logic [7:0]        seg;
  logic [7:0]        seg1;
  logic [DIGITS-1:0] an;

  modport master (
    output enable, load, num, dec_mode, blank_lz, dp, blink_mask,
    input  busy, seg, seg1, an
  );

  modport slave (
    input  enable, load, num, dec_mode, blank_lz, dp, blink_mask,
    output busy, seg, seg1, an
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment display driver. Latches a value on load and
// shows it in hex or in decimal (sequential double-dabble, one bit per
// cycle), with leading-zero blanking, per-digit dp, per-digit blink and an
// overflow dash display. Digits 0-3 drive seg, digits 4-7 drive seg1.
module seg_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int NUM_W        = 32,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic     clk,
  input  logic     rst,
  seg_scan_if.slave bus
);

  // BCD digits needed for the full NUM_W range (log10(2) < 0.31)
  localparam int BCD_N   = (NUM_W * 31) / 100 + 1;
  localparam int IDX_W   = $clog2(DIGITS);
  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int CNT_W   = $clog2(NUM_W + 1);

  logic [3:0]         digit_q [DIGITS];
  logic               ovf_q;
  logic               busy_q;
  logic [CNT_W-1:0]   iter_q;
  logic [NUM_W-1:0]   bin_q;
  logic [4*BCD_N-1:0] bcd_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [FRAME_W-1:0] frame_q;
  logic               phase_q;

  logic [4*BCD_N-1:0] bcd_adj, bcd_nxt;
  logic [NUM_W-1:0]   bin_nxt;
  logic               hex_ovf, dec_ovf;
  logic [DIGITS-1:0]  blank_vec;
  logic               seen_nz;
  logic [6:0]         glyph_c;
  logic [7:0]         seg_c;
  logic               dwell_tc, idx_last, frame_last;

  logic [DIGITS-1:0]  an_p1;
  logic [7:0]         seg_p1, seg1_p1;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // One double-dabble step: add 3 to nibbles >= 5, then shift the next binary bit in
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < BCD_N; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
    {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;
  end

  // Overflow flags: hex bits above the display, decimal nibbles above the display
  always_comb begin
    hex_ovf = (bus.num >> (4 * DIGITS)) != '0;
    dec_ovf = 1'b0;
    for (int n = DIGITS; n < BCD_N; n++) begin
      if (bcd_nxt[4*n +: 4] != 4'd0) dec_ovf = 1'b1;
    end
  end

  // Conversion control and display register; a new load always wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      iter_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= 4'd0;
    end else if (bus.load) begin
      if (bus.dec_mode) begin
        busy_q <= 1'b1;
        iter_q <= CNT_W'(NUM_W);
      end else begin
        busy_q <= 1'b0;
        iter_q <= '0;
        ovf_q  <= hex_ovf;
        for (int i = 0; i < DIGITS; i++) digit_q[i] <= bus.num[4*i +: 4];
      end
    end else if (busy_q) begin
      iter_q <= iter_q - CNT_W'(1);
      if (iter_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
        ovf_q  <= dec_ovf;
        for (int i = 0; i < DIGITS; i++) digit_q[i] <= bcd_nxt[4*i +: 4];
      end
    end
  end

  // Double-dabble shift registers; contents only matter while busy
  always_ff @(posedge clk) begin
    if (bus.load) begin
      bin_q <= bus.num;
      bcd_q <= '0;
    end else if (busy_q) begin
      bin_q <= bin_nxt;
      bcd_q <= bcd_nxt;
    end
  end

  assign dwell_tc   = dwell_q == DWELL_W'(SCAN_DIV - 1);
  assign idx_last   = idx_q == IDX_W'(DIGITS - 1);
  assign frame_last = frame_q == FRAME_W'(BLINK_FRAMES - 1);

  // Scan position, frame count and blink phase; all frozen while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if (bus.enable) begin
      if (dwell_tc) begin
        dwell_q <= '0;
        if (idx_last) begin
          idx_q <= '0;
          if (frame_last) begin
            frame_q <= '0;
            phase_q <= ~phase_q;
          end else begin
            frame_q <= frame_q + FRAME_W'(1);
          end
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end else begin
        dwell_q <= dwell_q + DWELL_W'(1);
      end
    end
  end

  // Leading-zero map: a digit is blankable when it and all digits above are zero
  always_comb begin
    seen_nz   = 1'b0;
    blank_vec = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (digit_q[i] != 4'd0) seen_nz = 1'b1;
      blank_vec[i] = ~seen_nz;
    end
  end

  // Segment pattern of the active digit: ovf dash, blanking, dp, then blink
  always_comb begin
    if (ovf_q)                                glyph_c = 7'h40;
    else if (bus.blank_lz && blank_vec[idx_q]) glyph_c = 7'h00;
    else                                      glyph_c = glyph(digit_q[idx_q]);
    seg_c = {bus.dp[idx_q], glyph_c};
    if (phase_q && bus.blink_mask[idx_q]) seg_c = 8'h00;
  end

  // Registered output stage: digit enable and segment bank select
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_p1   <= '0;
      seg_p1  <= 8'h00;
      seg1_p1 <= 8'h00;
    end else if (!bus.enable) begin
      an_p1   <= '0;
      seg_p1  <= 8'h00;
      seg1_p1 <= 8'h00;
    end else begin
      an_p1 <= DIGITS'(1) << idx_q;
      if (int'(idx_q) < 4) begin
        seg_p1  <= seg_c;
        seg1_p1 <= 8'h00;
      end else begin
        seg_p1  <= 8'h00;
        seg1_p1 <= seg_c;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.an   = an_p1;
  assign bus.seg  = seg_p1;
  assign bus.seg1 = seg1_p1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver. A reference model derives each
// cycle's expected outputs from elapsed enabled time and arithmetic digit
// extraction; a monitor pops and compares on the falling edge.
module tb_seg_scan_driver;

  localparam int DIGITS       = 8;
  localparam int NUM_W        = 32;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;
    logic [7:0]        seg1;
    logic              busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_if #(.DIGITS(DIGITS), .NUM_W(NUM_W)) bus ();

  seg_scan_driver #(
    .DIGITS(DIGITS), .NUM_W(NUM_W), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  exp_t q[$];

  // Reference model state
  longint unsigned ecnt;
  logic [3:0]      mdig [DIGITS];
  bit              movf;
  int              pend;
  longint unsigned pval;

  function automatic logic [7:0] exp_seg(input int i, input bit ph);
    int hi;
    logic [6:0] g;
    if (ph && bus.blink_mask[i]) return 8'h00;
    hi = 0;
    for (int k = 0; k < DIGITS; k++) if (mdig[k] != 4'd0) hi = k;
    if (movf)                      g = 7'h40;
    else if (bus.blank_lz && i > hi) g = 7'h00;
    else                           g = GLYPH[mdig[i]];
    return {bus.dp[i], g};
  endfunction

  always @(posedge clk) begin : model
    exp_t e;
    int idx;
    bit ph;
    logic [7:0] s;
    longint unsigned p;
    e.an = '0; e.seg = 8'h00; e.seg1 = 8'h00; e.busy = 1'b0;
    if (rst) begin
      ecnt = 0; movf = 0; pend = 0; pval = 0;
      for (int i = 0; i < DIGITS; i++) mdig[i] = 4'd0;
    end else begin
      if (bus.enable) begin
        idx = int'((ecnt / SCAN_DIV) % DIGITS);
        ph  = ((ecnt / (SCAN_DIV * DIGITS * BLINK_FRAMES)) % 2) == 1;
        s   = exp_seg(idx, ph);
        e.an = DIGITS'(1) << idx;
        if (idx < 4) e.seg = s; else e.seg1 = s;
        ecnt++;
      end
      if (bus.load) begin
        pval = 64'(bus.num);
        if (bus.dec_mode) begin
          pend = NUM_W;
        end else begin
          pend = 0;
          for (int i = 0; i < DIGITS; i++) mdig[i] = 4'(pval >> (4 * i));
          movf = (pval >> (4 * DIGITS)) != 0;
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          p = 1;
          for (int i = 0; i < DIGITS; i++) begin
            mdig[i] = 4'((pval / p) % 10);
            p = p * 10;
          end
          movf = pval >= p;
        end
      end
      e.busy = pend > 0;
    end
    q.push_back(e);
  end

  // Monitor: one expected entry per clock edge, compared away from the edge
  initial begin : monitor
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard_empty t=%0t: no expected entry for DUT outputs", $time);
      end else begin
        e = q.pop_front();
        if (bus.an !== e.an || bus.seg !== e.seg || bus.seg1 !== e.seg1 || bus.busy !== e.busy) begin
          mismatched++;
          $display("FAIL outputs t=%0t got an=%h seg=%h seg1=%h busy=%b expected an=%h seg=%h seg1=%h busy=%b",
                   $time, bus.an, bus.seg, bus.seg1, bus.busy, e.an, e.seg, e.seg1, e.busy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_load(input logic [NUM_W-1:0] v, input logic dm);
    bus.num      = v;
    bus.dec_mode = dm;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.enable = 1'b0; bus.load = 1'b0; bus.num = '0; bus.dec_mode = 1'b0;
    bus.blank_lz = 1'b0; bus.dp = '0; bus.blink_mask = '0;
    run(3);
    rst = 1'b0;
    bus.enable = 1'b1;
    run(2 * DIGITS * SCAN_DIV);

    bus.blank_lz = 1'b1;
    do_load(32'h0000_A5F3, 1'b0);
    run(DIGITS * SCAN_DIV + 5);

    do_load(32'd12345678, 1'b1);
    run(NUM_W + DIGITS * SCAN_DIV);
    do_load(32'd100000000, 1'b1);
    run(NUM_W + DIGITS * SCAN_DIV);

    do_load(32'd99, 1'b1);
    run(1);
    do_load(32'd7, 1'b1);
    run(NUM_W + DIGITS * SCAN_DIV);

    do_load(32'd4294967295, 1'b1);
    run(3);
    do_load(32'h0000_0C0D, 1'b0);
    run(DIGITS * SCAN_DIV);

    bus.blank_lz   = 1'b0;
    bus.dp         = 8'h01;
    bus.blink_mask = 8'h01;
    run(4 * BLINK_FRAMES * DIGITS * SCAN_DIV);

    run(13);
    bus.enable = 1'b0;
    run(10);
    bus.enable = 1'b1;
    run(DIGITS * SCAN_DIV);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0)
        do_load(32'($urandom >> $urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else
        tick();
      if ($urandom_range(0, 19) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 39) == 0) begin
        bus.blank_lz   = 1'($urandom_range(0, 1));
        bus.dp         = DIGITS'($urandom);
        bus.blink_mask = DIGITS'($urandom);
      end
    end

    bus.enable = 1'b1;
    do_load(32'd555, 1'b1);
    run(5);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    compared++;
    if (bus.busy !== 1'b0 || bus.an !== '0 || bus.seg !== 8'h00 || bus.seg1 !== 8'h00) begin
      mismatched++;
      $display("FAIL async_reset got busy=%b an=%h seg=%h seg1=%h expected all zero",
               bus.busy, bus.an, bus.seg, bus.seg1);
    end
    run(2);
    rst = 1'b0;
    bus.blank_lz = 1'b1;
    bus.blink_mask = '0;
    run(DIGITS * SCAN_DIV + 3);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
